rst_seq_ctrl: RTL and testbench

//  Ordered reset-release sequencer for the multi-clock system. Drives one reset request per

---
 rtl/rst_seq_ctrl_pkg.sv | 61 ++++++
 rtl/rst_seq_ctrl_ack_sync.sv | 39 +++
 rtl/rst_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl_pkg
// Shared definitions for the ordered reset-release sequencer:
//   - 3-bit state encoding of the sequencer FSM
//   - constant helpers used to size the cycle counter and domain index
// No ports (package).
// ---------------------------------------------------------------------------
package rst_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_RELEASE  = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_GAP      = 3'd3,
      ST_RUN      = 3'd4,
      ST_ASSERT   = 3'd5,
      ST_FAULT    = 3'd6
   } state_t;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 32'sd0;
      rem    = value - 32'sd1;
      while (rem > 32'sd0) begin
         result = result + 32'sd1;
         rem    = rem >>> 32'sd1;
      end
      return result;
   endfunction

   // Width of a binary index over 'count' items, never narrower than one bit.
   function automatic int idx_width(input int count);
      int w;
      w = clog2(count);
      if (w < 32'sd1) begin
         w = 32'sd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/rst_seq_ctrl_ack_sync.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl_ack_sync
// Brings the per-domain reset acknowledges into the reference clock domain
// through a STAGES-deep flop chain per bit. Cleared asynchronously by RST.
// Ports:
//   CLK      in   reference clock
//   RST      in   asynchronous active-low clear
//   ack_raw  in   WIDTH  acknowledges from the domains (asynchronous)
//   ack_s    out  WIDTH  synchronized acknowledges (last chain stage)
// ---------------------------------------------------------------------------
module rst_seq_ctrl_ack_sync #(
   parameter int WIDTH  = 2,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] ack_raw,
   output logic [WIDTH-1:0] ack_s
);

   logic [WIDTH-1:0] stage_r [STAGES];

   // Synchronizer chain: stage 0 samples the raw ack, later stages shift it along.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 32'sd0; i < STAGES; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= ack_raw;
         for (int i = 32'sd1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign ack_s = stage_r[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
// Ordered reset-release sequencer in the always-on reference clock domain.
// Holds every domain in reset for HOLD_CYCLES, then releases domains in index
// order, waiting for each domain's synchronized acknowledge and a GAP_CYCLES
// pause before the next. A soft reset from RUN re-asserts the domains in
// reverse order, one per cycle, and restarts the sequence. A missing ack for
// ACK_TIMEOUT cycles parks the block in FAULT with every domain in reset.
// Ports:
//   CLK           in   reference clock
//   RST           in   asynchronous active-low reset
//   SOFT_RST_REQ  in   soft reset request (level, honoured in RUN and FAULT)
//   DOM_ACK       in   NUM_DOMAINS  per-domain "reset released" ack (async)
//   DOM_RST_N     out  NUM_DOMAINS  per-domain active-low reset request
//   SYS_READY     out  all domains released and acknowledged
//   BUSY          out  sequencing in progress (HOLD/RELEASE/WAIT_ACK/GAP/ASSERT)
//   TIMEOUT_ERR   out  sticky ack-timeout flag, cleared by soft reset in FAULT
// All outputs are registered.
// ---------------------------------------------------------------------------
module rst_seq_ctrl
   import rst_seq_ctrl_pkg::*;
#(
   parameter int NUM_DOMAINS = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   SOFT_RST_REQ,
   input  logic [NUM_DOMAINS-1:0] DOM_ACK,
   output logic [NUM_DOMAINS-1:0] DOM_RST_N,
   output logic                   SYS_READY,
   output logic                   BUSY,
   output logic                   TIMEOUT_ERR
);

   localparam int CNT_W = clog2(max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 32'sd1);
   localparam int IDX_W = idx_width(NUM_DOMAINS);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 32'sd1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 32'sd1);

   state_t                 state_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [IDX_W-1:0]       idx_r;
   logic [NUM_DOMAINS-1:0] dom_rst_n_r;
   logic                   sys_ready_r;
   logic                   busy_r;
   logic                   timeout_err_r;
   logic [NUM_DOMAINS-1:0] ack_s;
   logic                   ack_sel_s;

   rst_seq_ctrl_ack_sync #(
      .WIDTH  (NUM_DOMAINS),
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .CLK     (CLK),
      .RST     (RST),
      .ack_raw (DOM_ACK),
      .ack_s   (ack_s)
   );

   // Only the ack of the domain currently being released matters.
   assign ack_sel_s = ack_s[idx_r];

   // Sequencer FSM with its counter, domain index and all output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r       <= ST_HOLD;
         cnt_r         <= CNT_ZERO;
         idx_r         <= IDX_ZERO;
         dom_rst_n_r   <= {NUM_DOMAINS{1'b0}};
         sys_ready_r   <= 1'b0;
         busy_r        <= 1'b1;
         timeout_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_r <= ST_RELEASE;
                  idx_r   <= IDX_ZERO;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_RELEASE: begin
               dom_rst_n_r[idx_r] <= 1'b1;
               state_r            <= ST_WAIT_ACK;
               cnt_r              <= CNT_ZERO;
            end
            ST_WAIT_ACK: begin
               // Ack is checked first so an ack landing on the last
               // allowed cycle still counts as success.
               if (ack_sel_s) begin
                  cnt_r <= CNT_ZERO;
                  if (idx_r == IDX_LAST) begin
                     state_r     <= ST_RUN;
                     sys_ready_r <= 1'b1;
                     busy_r      <= 1'b0;
                  end else begin
                     state_r <= ST_GAP;
                  end
               end else if (cnt_r == ACK_LAST) begin
                  state_r       <= ST_FAULT;
                  timeout_err_r <= 1'b1;
                  dom_rst_n_r   <= {NUM_DOMAINS{1'b0}};
                  sys_ready_r   <= 1'b0;
                  busy_r        <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  idx_r   <= idx_r + IDX_ONE;
                  state_r <= ST_RELEASE;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_RUN: begin
               // DOM_ACK is deliberately not watched here.
               if (SOFT_RST_REQ) begin
                  state_r     <= ST_ASSERT;
                  idx_r       <= IDX_LAST;
                  sys_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_ASSERT: begin
               // Drop domains highest index first, one per cycle.
               dom_rst_n_r[idx_r] <= 1'b0;
               if (idx_r == IDX_ZERO) begin
                  state_r <= ST_HOLD;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  idx_r <= idx_r - IDX_ONE;
               end
            end
            ST_FAULT: begin
               if (SOFT_RST_REQ) begin
                  timeout_err_r <= 1'b0;
                  state_r       <= ST_HOLD;
                  cnt_r         <= CNT_ZERO;
                  idx_r         <= IDX_ZERO;
                  busy_r        <= 1'b1;
               end else begin
                  state_r <= ST_FAULT;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a full reset hold.
               state_r     <= ST_HOLD;
               cnt_r       <= CNT_ZERO;
               idx_r       <= IDX_ZERO;
               dom_rst_n_r <= {NUM_DOMAINS{1'b0}};
               sys_ready_r <= 1'b0;
               busy_r      <= 1'b1;
            end
         endcase
      end
   end

   assign DOM_RST_N   = dom_rst_n_r;
   assign SYS_READY   = sys_ready_r;
   assign BUSY        = busy_r;
   assign TIMEOUT_ERR = timeout_err_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Scoreboard bench for rst_seq_ctrl (defaults: 2 domains, hold 8, gap 4,
// timeout 255, 2 sync stages). Each domain's ack is its own reset request
// delayed by three CLK flops, optionally masked per domain. Stimulus pushes
// the expected output word and the edge number (counted from the first RST
// release) at which it must appear; a monitor samples on the falling edge
// and pops one entry whenever the output word changes.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       SOFT_RST_REQ = 1'b0;
   logic [1:0] DOM_ACK;
   logic [1:0] DOM_RST_N;
   logic       SYS_READY;
   logic       BUSY;
   logic       TIMEOUT_ERR;

   logic [1:0] d1 = 2'b00;
   logic [1:0] d2 = 2'b00;
   logic [1:0] d3 = 2'b00;
   logic [1:0] ack_mask = 2'b11;
   int         cyc = 0;
   bit         run = 1'b0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [4:0] val;   // {DOM_RST_N, SYS_READY, BUSY, TIMEOUT_ERR}
      int         at;    // edge number where it must first be visible
   } ev_t;
   ev_t        exp_q[$];
   logic [4:0] prev_v;
   bit         first = 1'b1;

   always #5 CLK = ~CLK;

   rst_seq_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .SOFT_RST_REQ (SOFT_RST_REQ),
      .DOM_ACK      (DOM_ACK),
      .DOM_RST_N    (DOM_RST_N),
      .SYS_READY    (SYS_READY),
      .BUSY         (BUSY),
      .TIMEOUT_ERR  (TIMEOUT_ERR)
   );

   // Domain model: ack follows reset request after three CLK cycles; edge counter.
   always @(posedge CLK) begin
      d1 <= DOM_RST_N;
      d2 <= d1;
      d3 <= d2;
      if (run) cyc <= cyc + 1;
   end

   assign DOM_ACK = d3 & ack_mask;

   // Monitor: every change of the output word is checked against the queue head.
   always @(negedge CLK) begin
      logic [4:0] cur;
      ev_t        e;
      cur = {DOM_RST_N, SYS_READY, BUSY, TIMEOUT_ERR};
      if (first || cur !== prev_v) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: cyc=%0d got=%b, required no change", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e.val || cyc != e.at) begin
               errors++;
               $display("FAIL out_event: got %b at cyc %0d, required %b at cyc %0d",
                        cur, cyc, e.val, e.at);
            end
         end
      end
      first  = 1'b0;
      prev_v = cur;
   end

   task automatic push(input logic [1:0] dom, input logic rdy, input logic bsy,
                       input logic terr, input int at);
      ev_t e;
      e.val = {dom, rdy, bsy, terr};
      e.at  = at;
      exp_q.push_back(e);
   endtask

   // Full release sequence when HOLD starts counting after edge f.
   task automatic seq_from(input int f);
      push(2'b01, 1'b0, 1'b1, 1'b0, f + 9);
      push(2'b11, 1'b0, 1'b1, 1'b0, f + 20);
      push(2'b11, 1'b1, 1'b0, 1'b0, f + 26);
   endtask

   // RUN -> ASSERT at edge s, then resets drop 1 then 0.
   task automatic assert_from(input int s);
      push(2'b11, 1'b0, 1'b1, 1'b0, s);
      push(2'b01, 1'b0, 1'b1, 1'b0, s + 1);
      push(2'b00, 1'b0, 1'b1, 1'b0, s + 2);
   endtask

   // Returns on the falling edge after edge n.
   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge CLK);
   endtask

   // SOFT_RST_REQ high for exactly the rising edge 'at'.
   task automatic soft_pulse(input int at);
      wait_cyc(at - 1);
      SOFT_RST_REQ = 1'b1;
      @(negedge CLK);
      SOFT_RST_REQ = 1'b0;
   endtask

   initial begin
      // Power-up: reset values, then 01 at edge 9, 11 at 20, ready at 26.
      push(2'b00, 1'b0, 1'b1, 1'b0, 0);
      seq_from(0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      run = 1'b1;

      // Soft reset pulse in RUN: 11->01->00, hold, re-release.
      assert_from(40);
      seq_from(42);
      soft_pulse(40);

      // Domain 1 never acks: FAULT 255 cycles after WAIT_ACK(1) entry at 102.
      wait_cyc(70);
      ack_mask = 2'b01;
      assert_from(80);
      push(2'b01, 1'b0, 1'b1, 1'b0, 91);
      push(2'b11, 1'b0, 1'b1, 1'b0, 102);
      push(2'b00, 1'b0, 1'b0, 1'b1, 357);
      soft_pulse(80);
      wait_cyc(365);
      ack_mask = 2'b11;
      push(2'b00, 1'b0, 1'b1, 1'b0, 370);
      seq_from(370);
      soft_pulse(370);

      // Soft reset held high: ignored until RUN, then repeats from RUN.
      wait_cyc(400);
      SOFT_RST_REQ = 1'b1;
      assert_from(401);
      seq_from(403);
      assert_from(430);
      wait_cyc(431);
      SOFT_RST_REQ = 1'b0;
      seq_from(432);

      // RST pulsed low during GAP with DOM_RST_N=01.
      assert_from(470);
      push(2'b01, 1'b0, 1'b1, 1'b0, 481);
      soft_pulse(470);
      wait_cyc(488);
      @(posedge CLK);
      push(2'b00, 1'b0, 1'b1, 1'b0, 489);
      #1 RST = 1'b0;
      wait_cyc(491);
      RST = 1'b1;
      seq_from(491);

      // Ack seen on the last allowed WAIT_ACK cycle: proceeds to RUN, no fault.
      wait_cyc(520);
      ack_mask = 2'b01;
      assert_from(530);
      push(2'b01, 1'b0, 1'b1, 1'b0, 541);
      push(2'b11, 1'b0, 1'b1, 1'b0, 552);
      push(2'b11, 1'b1, 1'b0, 1'b0, 807);
      soft_pulse(530);
      wait_cyc(804);
      ack_mask = 2'b11;

      wait_cyc(820);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: %0d expected events never seen, required 0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
